// File: rtl/pfracbrg_prog.sv
// pfracbrg_prog: runtime-programmable fractional baud rate generator with a segmented phase accumulator.
// Define PFRACBRG_PROG_MIDSTB_EN to build the mid-bit strobe; otherwise mid_stb_o is tied low.
module pfracbrg_prog #(
  parameter int                  ACC_BITS = 16,
  parameter int                  SEG_BITS = 8,
  parameter int                  OVS_BITS = 4,
  parameter logic [ACC_BITS-1:0] DEF_INC  = ACC_BITS'(32'd1677)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [ACC_BITS-1:0] inc_i,
  input  logic                inc_wr_i,
  output logic                inc_pend_o,
  output logic                ovs_stb_o,
  output logic                ovs_clk_o,
  output logic                bit_stb_o,
  output logic                mid_stb_o
);

  localparam int                  NSEG     = ACC_BITS / SEG_BITS;
  localparam logic [OVS_BITS-1:0] CNT_LAST = {OVS_BITS{1'b1}};

  logic [SEG_BITS-1:0]           seg_q [NSEG];
  logic [SEG_BITS-1:0]           seg_d [NSEG];
  logic [SEG_BITS:0]             sum   [NSEG];
  logic [NSEG-1:0]               carry_q;
  logic [NSEG-1:0]               carry_d;
  logic [NSEG-1:0]               cin;
  logic [NSEG-1:0][SEG_BITS-1:0] inc_slice;
  logic [ACC_BITS-1:0]           inc_act_q;
  logic [ACC_BITS-1:0]           inc_act_d;
  logic [ACC_BITS-1:0]           shadow_q;
  logic [ACC_BITS-1:0]           shadow_d;
  logic [ACC_BITS-1:0]           inc_seg0;
  logic                          pend_q;
  logic                          pend_d;
  logic [OVS_BITS-1:0]           cnt_q;
  logic [OVS_BITS-1:0]           cnt_d;
  logic                          ovs_clk_q;
  logic                          ovs_clk_d;
  logic                          bit_stb_q;
  logic                          bit_stb_d;
  logic                          apply_tick;
  logic                          apply_now;
  logic                          tick_d;

  // A tick with a pending shadow feeds the new increment to segment 0 in that same cycle.
  always_comb begin
    apply_tick = carry_q[NSEG-1] & pend_q;
    apply_now  = apply_tick | (clr_i & pend_q);
    if (apply_tick) begin
      inc_seg0 = shadow_q;
    end else begin
      inc_seg0 = inc_act_q;
    end
  end

  assign inc_slice[0] = inc_seg0[SEG_BITS-1:0];

  // Segment k sees its increment slice k cycles late, matching the carry ripple skew.
  for (genvar k = 1; k < NSEG; k++) begin : g_skew
    logic [SEG_BITS-1:0] dly_q [k];
    logic [SEG_BITS-1:0] dly_d [k];

    always_comb begin
      dly_d = dly_q;
      if (clr_i) begin
        for (int j = 0; j < k; j++) dly_d[j] = {SEG_BITS{1'b0}};
      end else if (en_i) begin
        dly_d[0] = inc_seg0[k*SEG_BITS +: SEG_BITS];
        for (int j = 1; j < k; j++) dly_d[j] = dly_q[j-1];
      end else begin
        dly_d = dly_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int j = 0; j < k; j++) dly_q[j] <= {SEG_BITS{1'b0}};
      end else begin
        dly_q <= dly_d;
      end
    end

    assign inc_slice[k] = dly_q[k-1];
  end

  // Segment adders, tick derivation, oversample counter and increment hand-off.
  always_comb begin
    cin[0] = 1'b0;
    for (int k = 1; k < NSEG; k++) cin[k] = carry_q[k-1];
    for (int k = 0; k < NSEG; k++) begin
      sum[k] = {1'b0, seg_q[k]} + {1'b0, inc_slice[k]} + (SEG_BITS+1)'(cin[k]);
    end

    seg_d   = seg_q;
    carry_d = carry_q;
    if (clr_i) begin
      for (int k = 0; k < NSEG; k++) seg_d[k] = {SEG_BITS{1'b0}};
      carry_d = {NSEG{1'b0}};
    end else if (en_i) begin
      for (int k = 0; k < NSEG; k++) begin
        seg_d[k]   = sum[k][SEG_BITS-1:0];
        carry_d[k] = sum[k][SEG_BITS];
      end
    end else begin
      // The top carry is the emitted tick; it was already counted, so it drops rather than holds.
      carry_d[NSEG-1] = 1'b0;
    end
    tick_d = carry_d[NSEG-1];

    if (clr_i) begin
      cnt_d     = {OVS_BITS{1'b0}};
      ovs_clk_d = 1'b0;
      bit_stb_d = 1'b0;
    end else begin
      cnt_d     = cnt_q + OVS_BITS'(tick_d);
      ovs_clk_d = ovs_clk_q ^ tick_d;
      bit_stb_d = tick_d & (cnt_q == CNT_LAST);
    end

    if (apply_now) begin
      inc_act_d = shadow_q;
    end else begin
      inc_act_d = inc_act_q;
    end
    // A write in the apply cycle stays behind in the shadow and keeps the pending flag.
    if (inc_wr_i) begin
      shadow_d = inc_i;
      pend_d   = 1'b1;
    end else if (apply_now) begin
      shadow_d = shadow_q;
      pend_d   = 1'b0;
    end else begin
      shadow_d = shadow_q;
      pend_d   = pend_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NSEG; k++) seg_q[k] <= {SEG_BITS{1'b0}};
      carry_q   <= {NSEG{1'b0}};
      inc_act_q <= DEF_INC;
      shadow_q  <= {ACC_BITS{1'b0}};
      pend_q    <= 1'b0;
      cnt_q     <= {OVS_BITS{1'b0}};
      ovs_clk_q <= 1'b0;
      bit_stb_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      carry_q   <= carry_d;
      inc_act_q <= inc_act_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      ovs_clk_q <= ovs_clk_d;
      bit_stb_q <= bit_stb_d;
    end
  end

`ifdef PFRACBRG_PROG_MIDSTB_EN
  localparam logic [OVS_BITS-1:0] CNT_MID_PRE = OVS_BITS'((32'd1 << (OVS_BITS-1)) - 32'd1);

  logic mid_stb_q;
  logic mid_stb_d;

  // Mid-bit strobe fires with the tick that moves the counter to half scale.
  always_comb begin
    if (clr_i) begin
      mid_stb_d = 1'b0;
    end else begin
      mid_stb_d = tick_d & (cnt_q == CNT_MID_PRE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mid_stb_q <= 1'b0;
    end else begin
      mid_stb_q <= mid_stb_d;
    end
  end

  assign mid_stb_o = mid_stb_q;
`else
  assign mid_stb_o = 1'b0;
`endif

  assign inc_pend_o = pend_q;
  assign ovs_stb_o  = carry_q[NSEG-1];
  assign ovs_clk_o  = ovs_clk_q;
  assign bit_stb_o  = bit_stb_q;

endmodule

// File: tb/tb_pfracbrg_prog.sv
// Directed self-checking bench for pfracbrg_prog (default parameters: 16-bit accumulator, 2 segments, 16x).
module tb_pfracbrg_prog;

`ifdef PFRACBRG_PROG_MIDSTB_EN
  localparam bit MID_EN = 1'b1;
`else
  localparam bit MID_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        clr_i;
  logic        en_i;
  logic [15:0] inc_i;
  logic        inc_wr_i;
  logic        inc_pend_o;
  logic        ovs_stb_o;
  logic        ovs_clk_o;
  logic        bit_stb_o;
  logic        mid_stb_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pfracbrg_prog dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .en_i       (en_i),
    .inc_i      (inc_i),
    .inc_wr_i   (inc_wr_i),
    .inc_pend_o (inc_pend_o),
    .ovs_stb_o  (ovs_stb_o),
    .ovs_clk_o  (ovs_clk_o),
    .bit_stb_o  (bit_stb_o),
    .mid_stb_o  (mid_stb_o)
  );

  // One rising edge, then park on the falling edge to sample and drive.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance until ovs_stb_o is seen high, at most 40 cycles.
  task automatic sync_tick(input string name);
    int guard = 0;
    while (ovs_stb_o !== 1'b1 && guard < 40) begin
      step();
      guard++;
    end
    if (ovs_stb_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s_sync: no ovs_stb_o within 40 cycles (got %b, want 1)", name, ovs_stb_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clr_i = 1'b0; en_i = 1'b1; inc_i = 16'h0000; inc_wr_i = 1'b0;
    step();
    step();
    tests++;
    if ({inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 00000",
               {inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o});
    end
  endtask

  task automatic test_def_rate();
    int n_stb = 0;
    int n_bit = 0;
    int n_mid = 0;
    int first = 0;
    bit mid_ok;
    rst_i = 1'b0;
    step();
    for (int j = 2; j < 2 + 65536; j++) begin
      step();
      if (ovs_stb_o === 1'b1) begin
        n_stb++;
        if (first == 0) first = j;
      end
      if (bit_stb_o === 1'b1) n_bit++;
      if (mid_stb_o === 1'b1) n_mid++;
    end
    tests++;
    if (n_stb != 1677) begin
      fails++;
      $display("FAIL def_rate_count: got %0d ticks want 1677", n_stb);
    end
    tests++;
    if (first != 41) begin
      fails++;
      $display("FAIL def_rate_first: first tick at cycle %0d want 41", first);
    end
    tests++;
    if (n_bit != 104 && n_bit != 105) begin
      fails++;
      $display("FAIL def_rate_bits: got %0d bit strobes want 104 or 105", n_bit);
    end
    tests++;
    mid_ok = MID_EN ? (n_mid == 104 || n_mid == 105) : (n_mid == 0);
    if (!mid_ok) begin
      fails++;
      $display("FAIL def_rate_mids: got %0d mid strobes want %s", n_mid, MID_EN ? "104 or 105" : "0");
    end
  endtask

  task automatic test_half_rate();
    logic [3:0] got;
    logic [3:0] exp;
    inc_i = 16'h8000; inc_wr_i = 1'b1;
    step();
    inc_wr_i = 1'b0;
    tests++;
    if (inc_pend_o !== 1'b1) begin
      fails++;
      $display("FAIL half_pend_set: got %b want 1", inc_pend_o);
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    tests++;
    if ({inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o} !== 5'b00000) begin
      fails++;
      $display("FAIL half_after_clr: got %b want 00000",
               {inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o});
    end
    for (int j = 1; j <= 70; j++) begin
      step();
      exp = {(j >= 3) && (j % 2 == 1),
             (j >= 3) && (((j - 3) % 4) < 2),
             (j == 33) || (j == 65),
             MID_EN && ((j == 17) || (j == 49))};
      got = {ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL half_rate cycle %0d: stb/clk/bit/mid got %b want %b", j, got, exp);
      end
    end
  endtask

  task automatic test_switch();
    logic [1:0] got;
    logic [1:0] exp;
    sync_tick("switch");
    inc_i = 16'h4000; inc_wr_i = 1'b1;
    for (int d = 1; d <= 14; d++) begin
      step();
      inc_wr_i = 1'b0;
      exp = {d <= 2, (d == 2) || (d >= 5 && ((d - 5) % 4) == 0)};
      got = {inc_pend_o, ovs_stb_o};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL switch cycle +%0d: pend/stb got %b want %b", d, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] got;
    logic [1:0] exp;
    sync_tick("b2b");
    inc_i = 16'h2000; inc_wr_i = 1'b1;
    for (int d = 1; d <= 50; d++) begin
      step();
      if (d == 1) inc_i = 16'h1000;
      if (d == 2) inc_wr_i = 1'b0;
      exp = {d <= 4, (d == 4) || (d == 17) || (d == 33) || (d == 49)};
      got = {inc_pend_o, ovs_stb_o};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL back_to_back cycle +%0d: pend/stb got %b want %b", d, got, exp);
      end
    end
  endtask

  task automatic test_zero_inc();
    logic [3:0] seen = 4'b0000;
    logic [1:0] got;
    logic [1:0] exp;
    inc_i = 16'h0000; inc_wr_i = 1'b1;
    step();
    inc_wr_i = 1'b0; clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    tests++;
    if (inc_pend_o !== 1'b0) begin
      fails++;
      $display("FAIL zero_pend_clr: got %b want 0", inc_pend_o);
    end
    for (int j = 0; j < 1000; j++) begin
      step();
      seen = seen | {ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o};
    end
    tests++;
    if (seen !== 4'b0000) begin
      fails++;
      $display("FAIL zero_no_ticks: stb/clk/bit/mid seen %b want 0000", seen);
    end
    inc_i = 16'h8000; inc_wr_i = 1'b1;
    step();
    inc_wr_i = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      seen = seen | {ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o};
    end
    tests++;
    if ({inc_pend_o, seen} !== 5'b10000) begin
      fails++;
      $display("FAIL zero_pend_hold: pend/seen got %b want 10000", {inc_pend_o, seen});
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      exp = {(j >= 3) && (j % 2 == 1), (j >= 3) && (((j - 3) % 4) < 2)};
      got = {ovs_stb_o, ovs_clk_o};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL zero_resume cycle %0d: stb/clk got %b want %b", j, got, exp);
      end
    end
  endtask

  task automatic test_en_hold();
    logic [1:0] got;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    tests++;
    got = {ovs_stb_o, ovs_clk_o};
    if (got !== 2'b01) begin
      fails++;
      $display("FAIL en_pre cycle 4: stb/clk got %b want 01", got);
    end
    en_i = 1'b0;
    for (int j = 5; j <= 9; j++) begin
      step();
      got = {ovs_stb_o, ovs_clk_o};
      tests++;
      if (got !== 2'b01) begin
        fails++;
        $display("FAIL en_hold cycle %0d: stb/clk got %b want 01", j, got);
      end
    end
    en_i = 1'b1;
    for (int j = 10; j <= 12; j++) begin
      step();
      got = {ovs_stb_o, ovs_clk_o};
      tests++;
      if (got !== ((j == 10) ? 2'b10 : (j == 11) ? 2'b00 : 2'b11)) begin
        fails++;
        $display("FAIL en_resume cycle %0d: stb/clk got %b want %b", j, got,
                 (j == 10) ? 2'b10 : (j == 11) ? 2'b00 : 2'b11);
      end
    end
  endtask

  task automatic test_reset_midrun();
    en_i = 1'b0; inc_i = 16'h2000; inc_wr_i = 1'b1;
    step();
    inc_wr_i = 1'b0;
    tests++;
    if (inc_pend_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_pend_before: got %b want 1", inc_pend_o);
    end
    rst_i = 1'b1; inc_i = 16'h4000; inc_wr_i = 1'b1;
    step();
    rst_i = 1'b0; inc_wr_i = 1'b0;
    tests++;
    if ({inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o} !== 5'b00000) begin
      fails++;
      $display("FAIL rst_midrun_outputs: got %b want 00000",
               {inc_pend_o, ovs_stb_o, ovs_clk_o, bit_stb_o, mid_stb_o});
    end
    en_i = 1'b1;
    for (int j = 1; j <= 85; j++) begin
      step();
      tests++;
      if (ovs_stb_o !== ((j == 41) || (j == 80))) begin
        fails++;
        $display("FAIL rst_def_rate cycle %0d: stb got %b want %b", j, ovs_stb_o, (j == 41) || (j == 80));
      end
    end
  endtask

  initial begin
    test_reset();
    test_def_rate();
    test_half_rate();
    test_switch();
    test_back_to_back();
    test_zero_inc();
    test_en_hold();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
